frogg_hop_ctrl: RTL and testbench

- Game sequencer for the frog sprite datapath.
- Turns single button presses into discrete, animated hops of fixed length. Also owns frog position, lives, score and the game-phase state machine.
- Its o_Frog_X/o_Frog_Y feed the sprite draw logic. Sits between the debounced button inputs, the collision detector and the renderer.

---
 rtl/frogg_hop_ctrl.sv | 251 +++++++++++++++++++++++++
 tb/tb_frogg_hop_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frogg_hop_ctrl.sv
// frogg_hop_ctrl: game sequencer for the frog sprite.
// Turns single direction presses into animated fixed-length hops. Also owns
// the frog position, lives, score and the game-phase state machine.
// Build option: define FROGG_HOP_QUEUE_EN to add a one-entry buffer that
// holds a press made mid-hop and replays it as soon as the hop completes.
module frogg_hop_ctrl #(
  parameter int c_GAME_WIDTH  = 640,
  parameter int c_GAME_HEIGHT = 480,
  parameter int c_FROG_SIZE   = 32,
  parameter int c_HOP_PIXELS  = 32,
  parameter int c_STEP_TICKS  = 255000,
  parameter int c_DEATH_TICKS = 25000000,
  parameter int c_START_LIVES = 3
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Start,
  input  logic       i_Up,
  input  logic       i_Dn,
  input  logic       i_Lt,
  input  logic       i_Rt,
  input  logic       i_Collision,
  output logic [9:0] o_Frog_X,
  output logic [9:0] o_Frog_Y,
  output logic [2:0] o_State,
  output logic       o_Hopping,
  output logic [7:0] o_Score,
  output logic [1:0] o_Lives,
  output logic       o_Game_Over
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READY = 3'd1,
    S_HOP   = 3'd2,
    S_DEAD  = 3'd3,
    S_WIN   = 3'd4,
    S_OVER  = 3'd5
  } state_t;

  // Field limits are compared in 11 bits so that a hop left/up from near
  // zero wraps to a large value and is rejected as out of field.
  localparam logic [10:0] c_X_MAX   = 11'(c_GAME_WIDTH - c_FROG_SIZE);
  localparam logic [10:0] c_Y_MAX   = 11'(c_GAME_HEIGHT - c_FROG_SIZE);
  localparam logic [10:0] c_HOP     = 11'(c_HOP_PIXELS);
  localparam logic [9:0]  c_X_START = 10'((c_GAME_WIDTH - c_FROG_SIZE) / 2);
  localparam logic [9:0]  c_Y_START = 10'(c_GAME_HEIGHT - c_FROG_SIZE);
  localparam logic [1:0]  c_LIVES   = 2'(c_START_LIVES);

  localparam int c_TICK_W  = (c_STEP_TICKS > 1) ? $clog2(c_STEP_TICKS) : 1;
  localparam int c_DEATH_W = (c_DEATH_TICKS > 1) ? $clog2(c_DEATH_TICKS) : 1;
  localparam int c_PIX_W   = $clog2(c_HOP_PIXELS + 1);

  localparam logic [c_TICK_W-1:0]  c_TICK_LAST  = c_TICK_W'(c_STEP_TICKS - 1);
  localparam logic [c_DEATH_W-1:0] c_DEATH_LAST = c_DEATH_W'(c_DEATH_TICKS - 1);
  localparam logic [c_PIX_W-1:0]   c_PIX_LAST   = c_PIX_W'(c_HOP_PIXELS - 1);

  // Direction vectors are one-hot: bit0 Up, bit1 Dn, bit2 Lt, bit3 Rt.
  state_t               r_state;
  logic                 r_hopping;
  logic                 r_game_over;
  logic [9:0]           r_x;
  logic [9:0]           r_y;
  logic [7:0]           r_score;
  logic [1:0]           r_lives;
  logic [c_TICK_W-1:0]  r_tick;
  logic [c_PIX_W-1:0]   r_pix;
  logic [c_DEATH_W-1:0] r_dtick;
  logic [3:0]           r_dir;
  logic [3:0]           r_btn_prev;
`ifdef FROGG_HOP_QUEUE_EN
  logic                 r_q_valid;
  logic [3:0]           r_q_dir;
`endif

  logic [3:0] w_btn;
  logic [3:0] w_press;
  logic       w_press_valid;
  logic       w_cand_valid;
  logic [3:0] w_cand_dir;
  logic       w_cand_legal;
  logic       w_tick_last;
  logic [9:0] w_x_step;
  logic [9:0] w_y_step;
  logic       w_hit;

  // True when a hop in direction dir from (x, y) lands fully inside the field.
  function automatic logic f_legal(input logic [3:0] dir, input logic [9:0] x,
                                   input logic [9:0] y);
    logic [10:0] x_ext;
    logic [10:0] y_ext;
    x_ext = {1'b0, x};
    y_ext = {1'b0, y};
    if (dir[0])      f_legal = (y_ext - c_HOP) <= c_Y_MAX;
    else if (dir[1]) f_legal = (y_ext + c_HOP) <= c_Y_MAX;
    else if (dir[2]) f_legal = (x_ext - c_HOP) <= c_X_MAX;
    else if (dir[3]) f_legal = (x_ext + c_HOP) <= c_X_MAX;
    else             f_legal = 1'b0;
  endfunction

  // A press is a rising edge; only a lone press in a cycle counts.
  assign w_btn         = {i_Rt, i_Lt, i_Dn, i_Up};
  assign w_press       = w_btn & ~r_btn_prev;
  assign w_press_valid = (w_press != 4'd0) && ((w_press & (w_press - 4'd1)) == 4'd0);

`ifdef FROGG_HOP_QUEUE_EN
  // A buffered move takes precedence over a fresh press in READY.
  assign w_cand_valid = r_q_valid | w_press_valid;
  assign w_cand_dir   = r_q_valid ? r_q_dir : w_press;
`else
  assign w_cand_valid = w_press_valid;
  assign w_cand_dir   = w_press;
`endif
  assign w_cand_legal = f_legal(w_cand_dir, r_x, r_y);

  // One-pixel step in the latched direction.
  assign w_tick_last = (r_tick == c_TICK_LAST);
  assign w_x_step    = r_x + {9'd0, r_dir[3]} - {9'd0, r_dir[2]};
  assign w_y_step    = r_y + {9'd0, r_dir[1]} - {9'd0, r_dir[0]};

  // Collisions only matter while the frog is live on the field.
  assign w_hit = i_Collision && ((r_state == S_READY) || (r_state == S_HOP));

  // Game-phase FSM: position, hop timing, lives, score and registered flags.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_state     <= S_IDLE;
      r_hopping   <= 1'b0;
      r_game_over <= 1'b0;
      r_x         <= c_X_START;
      r_y         <= c_Y_START;
      r_score     <= 8'd0;
      r_lives     <= c_LIVES;
      r_tick      <= '0;
      r_pix       <= '0;
      r_dtick     <= '0;
      r_dir       <= 4'd0;
      r_btn_prev  <= 4'd0;
`ifdef FROGG_HOP_QUEUE_EN
      r_q_valid   <= 1'b0;
      r_q_dir     <= 4'd0;
`endif
    end else begin
      r_btn_prev <= w_btn;
      if (w_hit) begin
        // Death freezes the frog where it is and aborts any hop.
        r_state   <= S_DEAD;
        r_hopping <= 1'b0;
        r_lives   <= (r_lives != 2'd0) ? (r_lives - 2'd1) : 2'd0;
        r_dtick   <= '0;
`ifdef FROGG_HOP_QUEUE_EN
        r_q_valid <= 1'b0;
`endif
      end else begin
        case (r_state)
          S_IDLE: begin
            if (i_Start) r_state <= S_READY;
          end
          S_READY: begin
            if (w_cand_valid && w_cand_legal) begin
              r_state   <= S_HOP;
              r_hopping <= 1'b1;
              r_dir     <= w_cand_dir;
              r_tick    <= '0;
              r_pix     <= '0;
            end
`ifdef FROGG_HOP_QUEUE_EN
            // The buffer is either consumed or discarded here.
            r_q_valid <= 1'b0;
`endif
          end
          S_HOP: begin
`ifdef FROGG_HOP_QUEUE_EN
            if (w_press_valid) begin
              r_q_valid <= 1'b1;
              r_q_dir   <= w_press;
            end
`endif
            if (w_tick_last) begin
              r_tick <= '0;
              r_x    <= w_x_step;
              r_y    <= w_y_step;
              r_pix  <= r_pix + c_PIX_W'(1);
              if (r_pix == c_PIX_LAST) begin
                r_hopping <= 1'b0;
                if (w_y_step == 10'd0) begin
                  r_state <= S_WIN;
`ifdef FROGG_HOP_QUEUE_EN
                  r_q_valid <= 1'b0;
`endif
                end else begin
                  r_state <= S_READY;
                end
              end
            end else begin
              r_tick <= r_tick + c_TICK_W'(1);
            end
          end
          S_DEAD: begin
            if (r_dtick == c_DEATH_LAST) begin
              r_dtick <= '0;
              r_x     <= c_X_START;
              r_y     <= c_Y_START;
              if (r_lives == 2'd0) begin
                r_state     <= S_OVER;
                r_game_over <= 1'b1;
              end else begin
                r_state <= S_READY;
              end
            end else begin
              r_dtick <= r_dtick + c_DEATH_W'(1);
            end
          end
          S_WIN: begin
            r_score <= (r_score == 8'hFF) ? 8'hFF : (r_score + 8'd1);
            r_x     <= c_X_START;
            r_y     <= c_Y_START;
            r_state <= S_READY;
`ifdef FROGG_HOP_QUEUE_EN
            r_q_valid <= 1'b0;
`endif
          end
          S_OVER: begin
            if (i_Start) begin
              r_lives     <= c_LIVES;
              r_score     <= 8'd0;
              r_x         <= c_X_START;
              r_y         <= c_Y_START;
              r_state     <= S_READY;
              r_game_over <= 1'b0;
            end
          end
          default: begin
            r_state     <= S_IDLE;
            r_hopping   <= 1'b0;
            r_game_over <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_Frog_X    = r_x;
  assign o_Frog_Y    = r_y;
  assign o_State     = r_state;
  assign o_Hopping   = r_hopping;
  assign o_Score     = r_score;
  assign o_Lives     = r_lives;
  assign o_Game_Over = r_game_over;

endmodule

// File: tb/tb_frogg_hop_ctrl.sv
// tb_frogg_hop_ctrl: directed bench for frogg_hop_ctrl with a cycle-level
// behavioural model (hop position derived from elapsed hop time) and a
// single compare process that also evaluates hand-computed checkpoints.
module tb_frogg_hop_ctrl;

  localparam int STEP  = 2;
  localparam int DEATH = 4;
  localparam int HOPPX = 32;
  localparam int XMAX  = 640 - 32;
  localparam int YMAX  = 480 - 32;
  localparam int XST   = (640 - 32) / 2;
  localparam int YST   = 480 - 32;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       up = 1'b0, dn = 1'b0, lt = 1'b0, rt = 1'b0;
  logic       coll = 1'b0;
  logic [9:0] o_x, o_y;
  logic [2:0] o_st;
  logic       o_hop;
  logic [7:0] o_score;
  logic [1:0] o_lives;
  logic       o_go;

  frogg_hop_ctrl #(
    .c_STEP_TICKS (STEP),
    .c_DEATH_TICKS(DEATH)
  ) dut (
    .i_Clk      (clk),
    .i_Rst      (rst),
    .i_Start    (start),
    .i_Up       (up),
    .i_Dn       (dn),
    .i_Lt       (lt),
    .i_Rt       (rt),
    .i_Collision(coll),
    .o_Frog_X   (o_x),
    .o_Frog_Y   (o_y),
    .o_State    (o_st),
    .o_Hopping  (o_hop),
    .o_Score    (o_score),
    .o_Lives    (o_lives),
    .o_Game_Over(o_go)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int       m_state, m_x, m_y, m_score, m_lives;
  int       m_dx, m_dy, m_x0, m_y0, m_e, m_d;
  int       m_qdx, m_qdy;
  bit       m_q;
  bit [3:0] m_prev;
  bit       m_live = 1'b0;

  task automatic m_die();
    m_state = 3;
    m_lives = (m_lives > 0) ? m_lives - 1 : 0;
    m_d     = 0;
    m_q     = 1'b0;
  endtask

  // Model advances on each rising edge from the inputs seen at that edge.
  always @(posedge clk) begin
    bit [3:0] btn, pr;
    bit       cv;
    int       cdx, cdy, tx, ty;
    btn = {rt, lt, dn, up};
    pr  = btn & ~m_prev;
    cv  = 1'b0;
    cdx = 0;
    cdy = 0;
    if (rst) begin
      m_state = 0; m_x = XST; m_y = YST; m_score = 0; m_lives = 3;
      m_prev = 4'd0; m_q = 1'b0; m_e = 0; m_d = 0; m_dx = 0; m_dy = 0;
      m_live = 1'b1;
    end else if (m_live) begin
      case (m_state)
        0: if (start) m_state = 1;
        1: begin
          if (coll) m_die();
          else begin
`ifdef FROGG_HOP_QUEUE_EN
            if (m_q) begin
              cv = 1'b1; cdx = m_qdx; cdy = m_qdy; m_q = 1'b0;
            end else
`endif
            if ($countones(pr) == 1) begin
              cv  = 1'b1;
              cdx = int'(pr[3]) - int'(pr[2]);
              cdy = int'(pr[1]) - int'(pr[0]);
            end
            tx = m_x + HOPPX * cdx;
            ty = m_y + HOPPX * cdy;
            if (cv && tx >= 0 && tx <= XMAX && ty >= 0 && ty <= YMAX) begin
              m_state = 2; m_dx = cdx; m_dy = cdy; m_x0 = m_x; m_y0 = m_y; m_e = 0;
            end
          end
        end
        2: begin
          if (coll) m_die();
          else begin
`ifdef FROGG_HOP_QUEUE_EN
            if ($countones(pr) == 1) begin
              m_q   = 1'b1;
              m_qdx = int'(pr[3]) - int'(pr[2]);
              m_qdy = int'(pr[1]) - int'(pr[0]);
            end
`endif
            m_e = m_e + 1;
            m_x = m_x0 + m_dx * (m_e / STEP);
            m_y = m_y0 + m_dy * (m_e / STEP);
            if (m_e == HOPPX * STEP) begin
              if (m_y == 0) begin m_state = 4; m_q = 1'b0; end
              else m_state = 1;
            end
          end
        end
        3: begin
          m_d = m_d + 1;
          if (m_d == DEATH) begin
            m_x = XST; m_y = YST;
            m_state = (m_lives == 0) ? 5 : 1;
          end
        end
        4: begin
          m_score = (m_score < 255) ? m_score + 1 : 255;
          m_x = XST; m_y = YST; m_state = 1; m_q = 1'b0;
        end
        5: if (start) begin
          m_lives = 3; m_score = 0; m_x = XST; m_y = YST; m_state = 1;
        end
        default: m_state = 0;
      endcase
      m_prev = btn;
    end
  end

  // ---------------- checkpoints queued by the stimulus ----------------
  string pin_nm  [0:79];
  int    pin_act [0:79];
  int    pin_exp [0:79];
  int    pin_wr = 0;
  int    pin_rd = 0;

  task automatic pin(input string nm, input int act, input int exp_v);
    if (pin_wr < 80) begin
      pin_nm[pin_wr]  = nm;
      pin_act[pin_wr] = act;
      pin_exp[pin_wr] = exp_v;
      pin_wr = pin_wr + 1;
    end
  endtask

  // ---------------- compare process ----------------
  int n_tests = 0;
  int n_fail  = 0;

  always @(negedge clk) begin
    #1;
    while (pin_rd < pin_wr) begin
      n_tests = n_tests + 1;
      if (pin_act[pin_rd] != pin_exp[pin_rd]) begin
        n_fail = n_fail + 1;
        $display("FAIL %s: got %0d expected %0d", pin_nm[pin_rd], pin_act[pin_rd], pin_exp[pin_rd]);
      end
      pin_rd = pin_rd + 1;
    end
    if (m_live) begin
      n_tests = n_tests + 1;
      if (int'(o_st) != m_state || int'(o_x) != m_x || int'(o_y) != m_y ||
          int'(o_score) != m_score || int'(o_lives) != m_lives ||
          o_hop != (m_state == 2) || o_go != (m_state == 5)) begin
        n_fail = n_fail + 1;
        $display("FAIL cycle t=%0t: got st=%0d x=%0d y=%0d sc=%0d lv=%0d hop=%0d go=%0d expected st=%0d x=%0d y=%0d sc=%0d lv=%0d hop=%0d go=%0d",
                 $time, o_st, o_x, o_y, o_score, o_lives, o_hop, o_go,
                 m_state, m_x, m_y, m_score, m_lives, (m_state == 2), (m_state == 5));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] m);
    {rt, lt, dn, up} = m;
    tick(1);
    {rt, lt, dn, up} = 4'b0000;
  endtask

  task automatic wait_hop(output int n);
    n = 0;
    while (o_hop && n < 200) begin
      n = n + 1;
      @(negedge clk);
    end
  endtask

  initial begin
    int n;
    tick(3);
    rst = 1'b0;
    $display("[TB] reset released");
    pin("rst_state", o_st, 0);
    pin("rst_x", o_x, 304);
    pin("rst_y", o_y, 448);
    pin("rst_lives", o_lives, 3);
    pin("rst_score", o_score, 0);
    pin("rst_go", o_go, 0);

    start = 1'b1; tick(1); start = 1'b0;
    $display("[TB] start pulse");
    pin("start_state", o_st, 1);

    press(4'b0010);
    $display("[TB] Dn at bottom edge");
    pin("dn_edge_state", o_st, 1);
    pin("dn_edge_y", o_y, 448);
    tick(1);
    press(4'b0101);
    $display("[TB] Up+Lt together");
    pin("dual_state", o_st, 1);
    pin("dual_x", o_x, 304);
    pin("dual_y", o_y, 448);
    tick(1);

    press(4'b0001);
    wait_hop(n);
    $display("[TB] first Up hop, %0d clocks", n);
    pin("hop1_len", n, 64);
    pin("hop1_state", o_st, 1);
    pin("hop1_x", o_x, 304);
    pin("hop1_y", o_y, 416);

    for (int i = 0; i < 13; i++) begin
      press(4'b0001);
      wait_hop(n);
      $display("[TB] Up hop %0d, %0d clocks, y=%0d", i + 2, n, o_y);
    end
    pin("win_state", o_st, 4);
    pin("win_y", o_y, 0);
    tick(1);
    pin("post_win_state", o_st, 1);
    pin("post_win_score", o_score, 1);
    pin("post_win_x", o_x, 304);
    pin("post_win_y", o_y, 448);

    press(4'b0001);
    tick(5);
    press(4'b1000);
    wait_hop(n);
    tick(1);
    $display("[TB] Rt pressed during Up hop");
`ifdef FROGG_HOP_QUEUE_EN
    pin("queued_state", o_st, 2);
    wait_hop(n);
    pin("queued_len", n, 64);
    pin("queued_x", o_x, 336);
`else
    pin("noqueue_state", o_st, 1);
    pin("noqueue_x", o_x, 304);
`endif
    pin("after_rt_y", o_y, 416);

    press(4'b0001);
    tick(10);
    coll = 1'b1; tick(1); coll = 1'b0;
    $display("[TB] collision mid-hop");
    pin("dead_state", o_st, 3);
    pin("dead_lives", o_lives, 2);
    pin("dead_y", o_y, 411);
`ifdef FROGG_HOP_QUEUE_EN
    pin("dead_x", o_x, 336);
`else
    pin("dead_x", o_x, 304);
`endif
    tick(3);
    pin("dead_hold_state", o_st, 3);
    pin("dead_hold_y", o_y, 411);
    tick(1);
    pin("respawn_state", o_st, 1);
    pin("respawn_x", o_x, 304);
    pin("respawn_y", o_y, 448);

    coll = 1'b1; tick(1); coll = 1'b0;
    $display("[TB] collision 2");
    pin("coll2_lives", o_lives, 1);
    tick(4);
    pin("coll2_respawn", o_st, 1);
    coll = 1'b1; tick(1); coll = 1'b0;
    $display("[TB] collision 3");
    pin("coll3_lives", o_lives, 0);
    tick(4);
    pin("over_state", o_st, 5);
    pin("over_go", o_go, 1);
    press(4'b0001);
    tick(1);
    pin("over_ignore_state", o_st, 5);
    start = 1'b1; tick(1); start = 1'b0;
    $display("[TB] restart from OVER");
    pin("restart_state", o_st, 1);
    pin("restart_lives", o_lives, 3);
    pin("restart_score", o_score, 0);
    pin("restart_go", o_go, 0);

    press(4'b0001);
    tick(6);
    rst = 1'b1; tick(1); rst = 1'b0;
    $display("[TB] reset mid-hop");
    pin("midrst_state", o_st, 0);
    pin("midrst_y", o_y, 448);
    pin("midrst_hop", o_hop, 0);
    start = 1'b1; tick(1); start = 1'b0;
    press(4'b1000);
    wait_hop(n);
    $display("[TB] Rt hop after reset, x=%0d", o_x);
    pin("rt_hop_x", o_x, 336);

    tick(3);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
